// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-latched 3-line interrupt controller feeding the next-PC logic
// Optional per-line enable mask: define INT_MASK_EN.
module int_ctrl #(
    parameter int          NUM_IRQ  = 3,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               PCWrite,
    input  logic [31:0]        epc_in,
    input  logic               epc_valid,
    input  logic               MRET,
`ifdef INT_MASK_EN
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
`endif
    output logic               INT_Signal,
    output logic               EXL_set,
    output logic [NUM_IRQ-1:0] INT_PEND,
    output logic [31:0]        SEPC,
    output logic [1:0]         INT_CAUSE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [31:0]        sepc_q, sepc_d;
    logic [1:0]         cause_q, cause_d;
    logic               int_sig_q, int_sig_d;
    logic               exl_q, exl_d;

    logic [NUM_IRQ-1:0] irq_en;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clear;
    logic [1:0]         sel;
    logic               accept;

`ifdef INT_MASK_EN
    logic [NUM_IRQ-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (mask_we) begin
            mask_d = mask_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign irq_en = mask_q;
`else
    assign irq_en = '1;
`endif

    assign rise     = irq_in & ~irq_prev_q;
    assign eligible = pend_q & irq_en;

    // Ascending scan so the highest eligible index wins.
    always_comb begin
        sel = 2'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i]) begin
                sel = i[1:0];
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && (eligible != '0) && PCWrite
                    && epc_valid && !MRET;

    always_comb begin
        clear = '0;
        if (accept) begin
            clear[sel] = 1'b1;
        end
    end

    // A fresh edge on the line being cleared must survive, so rise is OR-ed last.
    assign pend_d     = (pend_q & ~clear) | rise;
    assign irq_prev_d = irq_in;

    always_comb begin
        state_d   = state_q;
        sepc_d    = sepc_q;
        cause_d   = cause_q;
        int_sig_d = 1'b0;
        exl_d     = exl_q;
        case (state_q)
            ST_IDLE: begin
                exl_d = 1'b0;
                if (accept) begin
                    sepc_d    = epc_in;
                    cause_d   = sel;
                    int_sig_d = 1'b1;
                    state_d   = ST_TAKE;
                end
            end
            ST_TAKE: begin
                exl_d   = 1'b1;
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                exl_d = 1'b1;
                if (MRET) begin
                    exl_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                exl_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            irq_prev_q <= '0;
            pend_q     <= '0;
            sepc_q     <= PC_RESET;
            cause_q    <= 2'd0;
            int_sig_q  <= 1'b0;
            exl_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            pend_q     <= pend_d;
            sepc_q     <= sepc_d;
            cause_q    <= cause_d;
            int_sig_q  <= int_sig_d;
            exl_q      <= exl_d;
        end
    end

    assign INT_Signal = int_sig_q;
    assign EXL_set    = exl_q;
    assign INT_PEND   = pend_q;
    assign SEPC       = sepc_q;
    assign INT_CAUSE  = cause_q;

endmodule
